// File: rtl/mix_engine.sv
// Iterative lane-mixing engine: LANES x WIDTH registers loaded from a seed and scrambled
// by a four-phase round (ADD, CHAIN, XSH, MUL) for a programmable number of rounds.
module mix_engine #(
    parameter int WIDTH = 32,
    parameter int LANES = 8,
    parameter int RW    = 8,
    parameter int SHL   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LANES*WIDTH-1:0] seed_i,
    input  logic [RW-1:0]          rounds_i,
    output logic                   busy,
    output logic                   done,
    output logic [LANES*WIDTH-1:0] state_o,
    output logic [WIDTH-1:0]       digest_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [RW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] lane_q [LANES];
    logic [WIDTH-1:0] lane_d [LANES];
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] digest_acc;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        lane_d  = lane_q;
        acc     = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < LANES; i++) begin
                        lane_d[i] = seed_i[i*WIDTH +: WIDTH];
                    end
                    cnt_d   = rounds_i;
                    phase_d = 2'd0;
                    if (rounds_i != '0) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                phase_d = phase_q + 2'd1;
                unique case (phase_q)
                    2'd0: begin
                        for (int i = 0; i < LANES; i++) begin
                            lane_d[i] = lane_q[i] + WIDTH'(i);
                        end
                    end
                    2'd1: begin
                        // Ripple-carry style chain seeded by the last lane's old value.
                        acc = lane_q[LANES-1];
                        for (int i = 0; i < LANES; i++) begin
                            acc       = lane_q[i] + acc;
                            lane_d[i] = acc;
                        end
                    end
                    2'd2: begin
                        for (int i = 0; i < LANES; i++) begin
                            lane_d[i] = lane_q[i] ^ (lane_q[(i+3) % LANES] << SHL);
                        end
                    end
                    default: begin
                        for (int i = 0; i < LANES; i++) begin
                            lane_d[i] = lane_q[i] * WIDTH'(2*i+3) + WIDTH'(1);
                        end
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == RW'(1)) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            // NOTE: the lane array is reset element by element because state_o must read 0 right after reset.
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lane_q  <= lane_d;
        end
    end

    always_comb begin
        digest_acc = '0;
        for (int i = 0; i < LANES; i++) begin
            digest_acc = digest_acc ^ lane_q[i];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_pack
        assign state_o[g*WIDTH +: WIDTH] = lane_q[g];
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign digest_o = digest_acc;

endmodule

// File: tb/tb_mix_engine.sv
// Self-checking bench for mix_engine: default 8x32 instance plus a 5x24 (SHL=8) instance,
// compared against a round-level arithmetic reference model.
module tb_mix_engine;

    localparam int LIMIT = 1100;

    logic         clk;
    logic         rst;
    logic         start;
    logic [255:0] seed;
    logic [7:0]   rounds;
    logic         busy;
    logic         done;
    logic [255:0] state_v;
    logic [31:0]  digest;

    logic         start_s;
    logic [119:0] seed_s;
    logic [7:0]   rounds_s;
    logic         busy_s;
    logic         done_s;
    logic [119:0] state_s;
    logic [23:0]  digest_s;

    int checks   = 0;
    int failures = 0;

    mix_engine dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .seed_i   (seed),
        .rounds_i (rounds),
        .busy     (busy),
        .done     (done),
        .state_o  (state_v),
        .digest_o (digest)
    );

    mix_engine #(.WIDTH(24), .LANES(5), .RW(8), .SHL(8)) dut_s (
        .clk      (clk),
        .rst      (rst),
        .start    (start_s),
        .seed_i   (seed_s),
        .rounds_i (rounds_s),
        .busy     (busy_s),
        .done     (done_s),
        .state_o  (state_s),
        .digest_o (digest_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("comparison %s did not match", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Apply the round rules with plain 64-bit arithmetic, masked to the lane width.
    function automatic logic [255:0] model(input int width, input int lanes, input int shl,
                                           input int nrounds, input logic [255:0] seed_v);
        longint unsigned x [8];
        longint unsigned o [8];
        longint unsigned mask;
        longint unsigned prev;
        logic [255:0]    res;
        mask = (64'd1 << width) - 64'd1;
        for (int i = 0; i < lanes; i++) x[i] = 64'(seed_v >> (i*width)) & mask;
        for (int r = 0; r < nrounds; r++) begin
            for (int i = 0; i < lanes; i++) x[i] = (x[i] + 64'(i)) & mask;
            prev = x[lanes-1];
            for (int i = 0; i < lanes; i++) begin
                x[i] = (x[i] + prev) & mask;
                prev = x[i];
            end
            for (int i = 0; i < lanes; i++) o[i] = x[i];
            for (int i = 0; i < lanes; i++) x[i] = o[i] ^ ((o[(i+3) % lanes] << shl) & mask);
            for (int i = 0; i < lanes; i++) x[i] = (x[i] * 64'(2*i+3) + 64'd1) & mask;
        end
        res = '0;
        for (int i = 0; i < lanes; i++) res = res | (256'(x[i]) << (i*width));
        return res;
    endfunction

    function automatic logic [255:0] xor_lanes(input logic [255:0] v, input int width, input int lanes);
        logic [255:0] mask;
        logic [255:0] d;
        mask = (256'd1 << width) - 256'd1;
        d = '0;
        for (int i = 0; i < lanes; i++) d = d ^ ((v >> (i*width)) & mask);
        return d;
    endfunction

    // Caller drives start high at a negedge; counts edges from acceptance until done.
    task automatic run_measure(input bit sel, output int n_done, output int n_busy);
        n_done = 0;
        n_busy = 0;
        for (int k = 0; k < LIMIT; k++) begin
            tick();
            if (k == 0) begin
                start   = 1'b0;
                start_s = 1'b0;
            end
            n_done++;
            if (sel ? busy_s : busy) n_busy++;
            if (sel ? done_s : done) break;
        end
    endtask

    initial begin
        logic [255:0] v;
        logic [255:0] seed_a;
        logic [255:0] exp_v;
        int           vals [8];
        int           n;
        int           b;
        int           r;
        int           pulses;

        rst = 1'b0; start = 1'b0; seed = '0; rounds = '0;
        start_s = 1'b0; seed_s = '0; rounds_s = '0;
        #1 rst = 1'b1;
        tick();
        tick();
        check("reset_state", state_v, 256'd0);
        check("reset_busy", 256'(busy), 256'd0);
        check("reset_done", 256'(done), 256'd0);
        check("reset_digest", 256'(digest), 256'd0);
        rst = 1'b0;
        tick();

        // Zero seed, one round: phase-by-phase visibility.
        seed = '0; rounds = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("r1_busy_e0", 256'(busy), 256'd1);
        tick();
        tick();
        vals = '{7, 8, 10, 13, 17, 22, 28, 35};
        exp_v = '0;
        for (int i = 0; i < 8; i++) exp_v[i*32 +: 32] = 32'(vals[i]);
        check("r1_after_chain", state_v, exp_v);
        tick();
        check("r1_done_early", 256'(done), 256'd0);
        tick();
        check("r1_done", 256'(done), 256'd1);
        check("r1_busy_end", 256'(busy), 256'd0);
        v = state_v;
        check("r1_x0", 256'(v[31:0]), 256'h00270016);
        check("r1_x7", 256'(v[255:224]), 256'h00AA0254);
        exp_v = model(32, 8, 16, 1, 256'd0);
        check("r1_state", state_v, exp_v);
        check("r1_digest", 256'(digest), xor_lanes(exp_v, 32, 8));
        tick();
        check("r1_done_single", 256'(done), 256'd0);
        check("r1_hold", state_v, exp_v);

        // Zero rounds: seed passes straight through, done one edge later.
        for (int i = 0; i < 8; i++) seed[i*32 +: 32] = 32'(32'h11111111 * i);
        rounds = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("r0_done", 256'(done), 256'd1);
        check("r0_busy", 256'(busy), 256'd0);
        check("r0_state", state_v, seed);
        tick();
        check("r0_done_single", 256'(done), 256'd0);

        // Start hammered with fresh seeds/rounds during an R=3 run.
        seed_a = rand_vec();
        seed = seed_a; rounds = 8'd3; start = 1'b1;
        tick();
        n = 1;
        pulses = 0;
        while (n < LIMIT) begin
            if (done) begin
                pulses++;
                break;
            end
            seed = rand_vec(); rounds = 8'($urandom); start = 1'b1;
            tick();
            n++;
        end
        start = 1'b0;
        check("ham_latency", 256'(n), 256'd13);
        check("ham_state", state_v, model(32, 8, 16, 3, seed_a));
        tick();
        check("ham_done_single", 256'(done), 256'd0);

        // Back-to-back runs: start accepted in the done cycle.
        seed_a = rand_vec();
        seed = seed_a; rounds = 8'd2; start = 1'b1;
        run_measure(1'b0, n, b);
        check("b2b_first_latency", 256'(n), 256'd9);
        check("b2b_first_state", state_v, model(32, 8, 16, 2, seed_a));
        seed_a = rand_vec();
        seed = seed_a; rounds = 8'd2; start = 1'b1;
        run_measure(1'b0, n, b);
        check("b2b_second_latency", 256'(n), 256'd9);
        check("b2b_second_busy", 256'(b), 256'd8);
        check("b2b_second_state", state_v, model(32, 8, 16, 2, seed_a));

        // Random seeds and short round counts.
        for (int t = 0; t < 4; t++) begin
            seed_a = rand_vec();
            r = int'($urandom_range(1, 6));
            seed = seed_a; rounds = 8'(r); start = 1'b1;
            run_measure(1'b0, n, b);
            exp_v = model(32, 8, 16, r, seed_a);
            check("rand_latency", 256'(n), 256'(4*r+1));
            check("rand_state", state_v, exp_v);
            check("rand_digest", 256'(digest), xor_lanes(exp_v, 32, 8));
            tick();
        end

        // Asynchronous reset in the middle of a run.
        seed = rand_vec(); rounds = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_state", state_v, 256'd0);
        check("midrst_busy", 256'(busy), 256'd0);
        check("midrst_done", 256'(done), 256'd0);
        check("midrst_digest", 256'(digest), 256'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done) pulses++;
        end
        check("midrst_no_done", 256'(pulses), 256'd0);

        // Narrow instance, full 255 rounds.
        for (int t = 0; t < 2; t++) begin
            v = rand_vec();
            seed_s = v[119:0]; rounds_s = 8'd255; start_s = 1'b1;
            run_measure(1'b1, n, b);
            exp_v = model(24, 5, 8, 255, 256'(v[119:0]));
            check("sweep_latency", 256'(n), 256'd1021);
            check("sweep_busy", 256'(b), 256'd1020);
            check("sweep_state", 256'(state_s), exp_v);
            check("sweep_digest", 256'(digest_s), xor_lanes(exp_v, 24, 5));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
